pcie_rx_tlp_router: RTL and testbench

Consumes the PCIe endpoint's 64-bit AXI4-Stream RX TLP interface and routes each TLP by header type. Requests (memory and I/O) go to a request stream; completions go to a completion stream; everything else is discarded. The block also drives rx_np_ok, throttling non-posted requests according to how many are outstanding in the application. It sits directly downstream of the endpoint wrapper's m_axis_rx and rx_np_ok ports, in the user_clk domain.

---
 rtl/pcie_rx_tlp_router.sv | 240 ++++++++++++++++++++++++
 tb/tb_pcie_rx_tlp_router.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_tlp_router.sv
// RX TLP router: splits the endpoint m_axis_rx stream into request/completion streams and paces rx_np_ok.
// Define PCIE_RX_STATS_EN to build the per-path TLP counters; otherwise drop_cnt/req_cnt/cpl_cnt read 0.

module pcie_rx_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_full
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: r_count gates every read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

module pcie_rx_tlp_router #(
  parameter int NP_LIMIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             user_clk,
  input  logic             user_reset_n,
  input  logic [63:0]      rx_tdata,
  input  logic [7:0]       rx_tkeep,
  input  logic             rx_tlast,
  input  logic             rx_tvalid,
  input  logic [21:0]      rx_tuser,
  output logic             rx_tready,
  output logic             rx_np_ok,
  output logic [63:0]      req_tdata,
  output logic [7:0]       req_tkeep,
  output logic             req_tlast,
  output logic [6:0]       req_bar,
  output logic             req_np,
  output logic             req_tvalid,
  input  logic             req_tready,
  output logic [63:0]      cpl_tdata,
  output logic [7:0]       cpl_tkeep,
  output logic             cpl_tlast,
  output logic             cpl_tvalid,
  input  logic             cpl_tready,
  input  logic             np_done,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] cpl_cnt,
  output logic [1:0]       o_dbg_state
);
  typedef enum logic [1:0] {ST_SOP = 2'd0, ST_REQ = 2'd1, ST_CPL = 2'd2, ST_DROP = 2'd3} state_t;

  localparam logic [7:0] LP_NP_LIMIT = 8'(NP_LIMIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_out_en;
  logic [6:0]  r_bar;
  logic        r_np;
  logic [7:0]  r_np_cnt;
  logic        r_np_ok;
  logic [4:0]  w_type;
  logic        w_hdr_req;
  logic        w_hdr_np;
  logic        w_sop_req;
  logic        w_sop_cpl;
  logic        w_rx_tready;
  logic        w_acc;
  logic        w_sop_acc;
  logic        w_req_push;
  logic        w_cpl_push;
  logic        w_np_inc;
  logic        w_np_dec;
  logic        w_req_full;
  logic        w_cpl_full;
  logic [6:0]  w_beat_bar;
  logic        w_beat_np;
  logic [80:0] w_req_dout;
  logic [72:0] w_cpl_dout;
  logic        w_unused;

  // Header decode; only meaningful on the first beat of a TLP.
  assign w_type    = rx_tdata[28:24];
  assign w_hdr_req = (w_type == 5'b00000) || (w_type == 5'b00010);
  assign w_hdr_np  = w_hdr_req && (!rx_tdata[30] || (w_type == 5'b00010));
  assign w_sop_req = w_hdr_req && !rx_tuser[1];
  assign w_sop_cpl = (w_type == 5'b01010) && !rx_tuser[1];
  assign w_unused  = ^{rx_tuser[21:9], rx_tuser[0]};

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) r_state <= ST_SOP;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      if (r_state == ST_SOP) begin
        if (!rx_tlast) begin
          if (w_sop_req)      w_state_nxt = ST_REQ;
          else if (w_sop_cpl) w_state_nxt = ST_CPL;
          else                w_state_nxt = ST_DROP;
        end
      end else if (rx_tlast) begin
        w_state_nxt = ST_SOP;
      end
    end
  end

  // In SOP the route is unknown until decode, so both paths must have room.
  always_comb begin
    w_rx_tready = 1'b0;
    w_req_push  = 1'b0;
    w_cpl_push  = 1'b0;
    if (r_out_en) begin
      case (r_state)
        ST_SOP:  w_rx_tready = !w_req_full && !w_cpl_full;
        ST_REQ:  w_rx_tready = !w_req_full;
        ST_CPL:  w_rx_tready = !w_cpl_full;
        default: w_rx_tready = 1'b1;
      endcase
    end
    w_acc     = rx_tvalid && w_rx_tready;
    w_sop_acc = w_acc && (r_state == ST_SOP);
    if (w_acc) begin
      w_req_push = (r_state == ST_SOP) ? w_sop_req : (r_state == ST_REQ);
      w_cpl_push = (r_state == ST_SOP) ? w_sop_cpl : (r_state == ST_CPL);
    end
    w_np_inc = w_sop_acc && w_sop_req && w_hdr_np;
    w_np_dec = np_done && (r_np_cnt != 8'd0);
  end

  assign w_beat_bar = (r_state == ST_SOP) ? rx_tuser[8:2] : r_bar;
  assign w_beat_np  = (r_state == ST_SOP) ? w_hdr_np : r_np;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_out_en <= 1'b0;
      r_bar    <= 7'd0;
      r_np     <= 1'b0;
      r_np_cnt <= 8'd0;
      r_np_ok  <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (w_sop_acc && w_sop_req) begin
        r_bar <= rx_tuser[8:2];
        r_np  <= w_hdr_np;
      end
      case ({w_np_inc, w_np_dec})
        2'b10:   if (r_np_cnt != 8'hFF) r_np_cnt <= r_np_cnt + 8'd1;
        2'b01:   r_np_cnt <= r_np_cnt - 8'd1;
        default: r_np_cnt <= r_np_cnt;
      endcase
      r_np_ok <= (r_np_cnt < LP_NP_LIMIT);
    end
  end

  pcie_rx_skid #(.W(81)) u_req_skid (
    .clk     (user_clk),
    .rst_n   (user_reset_n),
    .i_push  (w_req_push),
    .i_data  ({rx_tdata, rx_tkeep, rx_tlast, w_beat_bar, w_beat_np}),
    .i_ready (req_tready),
    .o_valid (req_tvalid),
    .o_data  (w_req_dout),
    .o_full  (w_req_full)
  );

  pcie_rx_skid #(.W(73)) u_cpl_skid (
    .clk     (user_clk),
    .rst_n   (user_reset_n),
    .i_push  (w_cpl_push),
    .i_data  ({rx_tdata, rx_tkeep, rx_tlast}),
    .i_ready (cpl_tready),
    .o_valid (cpl_tvalid),
    .o_data  (w_cpl_dout),
    .o_full  (w_cpl_full)
  );

  assign {req_tdata, req_tkeep, req_tlast, req_bar, req_np} = w_req_dout;
  assign {cpl_tdata, cpl_tkeep, cpl_tlast}                  = w_cpl_dout;
  assign rx_tready   = w_rx_tready;
  assign rx_np_ok    = r_np_ok;
  assign o_dbg_state = r_state;

`ifdef PCIE_RX_STATS_EN
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_req_cnt;
  logic [CNT_W-1:0] r_cpl_cnt;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_drop_cnt <= '0;
      r_req_cnt  <= '0;
      r_cpl_cnt  <= '0;
    end else if (w_sop_acc) begin
      if (w_sop_req)      r_req_cnt  <= r_req_cnt + CNT_W'(1);
      else if (w_sop_cpl) r_cpl_cnt  <= r_cpl_cnt + CNT_W'(1);
      else                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign req_cnt  = r_req_cnt;
  assign cpl_cnt  = r_cpl_cnt;
`else
  assign drop_cnt = '0;
  assign req_cnt  = '0;
  assign cpl_cnt  = '0;
`endif
endmodule

// File: tb/tb_pcie_rx_tlp_router.sv
// Scoreboard bench for pcie_rx_tlp_router (NP_LIMIT=2): directed TLPs, per-path expected queues, negedge monitor.
// Counter checks follow PCIE_RX_STATS_EN when it is defined for the build.

module tb_pcie_rx_tlp_router;
  localparam int CNT_W = 16;

  // Clock / reset
  logic user_clk = 1'b0;
  logic user_reset_n = 1'b0;
  always #5 user_clk = ~user_clk;

  logic [63:0]      rx_tdata;
  logic [7:0]       rx_tkeep;
  logic             rx_tlast;
  logic             rx_tvalid;
  logic [21:0]      rx_tuser;
  logic             rx_tready;
  logic             rx_np_ok;
  logic [63:0]      req_tdata;
  logic [7:0]       req_tkeep;
  logic             req_tlast;
  logic [6:0]       req_bar;
  logic             req_np;
  logic             req_tvalid;
  logic             req_tready;
  logic [63:0]      cpl_tdata;
  logic [7:0]       cpl_tkeep;
  logic             cpl_tlast;
  logic             cpl_tvalid;
  logic             cpl_tready;
  logic             np_done;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] cpl_cnt;
  logic [1:0]       o_dbg_state;

  pcie_rx_tlp_router #(.NP_LIMIT(2), .CNT_W(CNT_W)) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .rx_tdata     (rx_tdata),
    .rx_tkeep     (rx_tkeep),
    .rx_tlast     (rx_tlast),
    .rx_tvalid    (rx_tvalid),
    .rx_tuser     (rx_tuser),
    .rx_tready    (rx_tready),
    .rx_np_ok     (rx_np_ok),
    .req_tdata    (req_tdata),
    .req_tkeep    (req_tkeep),
    .req_tlast    (req_tlast),
    .req_bar      (req_bar),
    .req_np       (req_np),
    .req_tvalid   (req_tvalid),
    .req_tready   (req_tready),
    .cpl_tdata    (cpl_tdata),
    .cpl_tkeep    (cpl_tkeep),
    .cpl_tlast    (cpl_tlast),
    .cpl_tvalid   (cpl_tvalid),
    .cpl_tready   (cpl_tready),
    .np_done      (np_done),
    .drop_cnt     (drop_cnt),
    .req_cnt      (req_cnt),
    .cpl_cnt      (cpl_cnt),
    .o_dbg_state  (o_dbg_state)
  );

  // Scoreboard state
  logic [80:0] exp_req_q[$];
  logic [72:0] exp_cpl_q[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_req_tlp = 0;
  int exp_cpl_tlp = 0;
  int exp_drop_tlp = 0;
  int req_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 stalled
  int cpl_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic drive_rdy(input int mode, input logic cur);
    case (mode)
      0:       return 1'b1;
      1:       return ~cur;
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] hdr(input logic [6:0] fmt_type, input logic [31:0] hi);
    return {hi, 1'b0, fmt_type, 24'h000001};
  endfunction

  function automatic logic [21:0] tu(input logic [6:0] bar, input logic err);
    return {13'd0, bar, err, 1'b0};
  endfunction

  // Sink ready drivers
  initial begin
    req_tready = 1'b0;
    cpl_tready = 1'b0;
    forever begin
      @(posedge user_clk);
      #1;
      req_tready = drive_rdy(req_mode, req_tready);
      cpl_tready = drive_rdy(cpl_mode, cpl_tready);
    end
  end

  // Monitor: a beat transfers at the next posedge when valid&ready are seen mid-cycle
  initial begin
    forever begin
      @(negedge user_clk);
      if (req_tvalid && req_tready) begin
        if (exp_req_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL req_unexpected: got %0h, expected no beat", req_tdata);
        end else begin
          check("req_beat", {req_tdata, req_tkeep, req_tlast, req_bar, req_np}, exp_req_q.pop_front());
        end
      end
      if (cpl_tvalid && cpl_tready) begin
        if (exp_cpl_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL cpl_unexpected: got %0h, expected no beat", cpl_tdata);
        end else begin
          check("cpl_beat", {cpl_tdata, cpl_tkeep, cpl_tlast}, exp_cpl_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [21:0] u, input int path, input logic [6:0] bar,
                           input logic np, input bit first);
    bit acc = 1'b0;
    if (path == 0) exp_req_q.push_back({d, k, l, bar, np});
    else if (path == 1) exp_cpl_q.push_back({d, k, l});
    if (first) begin
      if (path == 0) exp_req_tlp++;
      else if (path == 1) exp_cpl_tlp++;
      else exp_drop_tlp++;
    end
    rx_tdata  = d;
    rx_tkeep  = k;
    rx_tlast  = l;
    rx_tuser  = u;
    rx_tvalid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge user_clk);
      acc = rx_tready;
      @(posedge user_clk);
      #1;
    end
    rx_tvalid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL rx_accept_timeout: got rx_tready 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      if (exp_req_q.size() == 0 && exp_cpl_q.size() == 0) done = 1'b1;
      else step(1);
    end
    step(2);
    check("drain_req_left", exp_req_q.size(), 0);
    check("drain_cpl_left", exp_cpl_q.size(), 0);
  endtask

  task automatic pulse_np_done();
    np_done = 1'b1;
    step(1);
    np_done = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef PCIE_RX_STATS_EN
    check({tag, "_drop_cnt"}, drop_cnt, exp_drop_tlp);
    check({tag, "_req_cnt"}, req_cnt, exp_req_tlp);
    check({tag, "_cpl_cnt"}, cpl_cnt, exp_cpl_tlp);
`else
    check({tag, "_drop_cnt"}, drop_cnt, 0);
    check({tag, "_req_cnt"}, req_cnt, 0);
    check({tag, "_cpl_cnt"}, cpl_cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rx_tdata = '0; rx_tkeep = '0; rx_tlast = 1'b0; rx_tvalid = 1'b0; rx_tuser = '0; np_done = 1'b0;

    // Reset state, then ready/np_ok rise one cycle after release
    step(3);
    check("rst_rx_tready", rx_tready, 0);
    check("rst_np_ok", rx_np_ok, 0);
    check("rst_req_tvalid", req_tvalid, 0);
    check("rst_cpl_tvalid", cpl_tvalid, 0);
    check("rst_state", o_dbg_state, 0);
    check_stats("rst");
    user_reset_n = 1'b1;
    @(negedge user_clk);
    check("rel_rx_tready_early", rx_tready, 0);
    step(1);
    check("rel_rx_tready", rx_tready, 1);
    check("rel_np_ok", rx_np_ok, 1);

    // 4DW MWr, 3 beats, bar 1; later beats carry err_fwd and a Cpl-like pattern that must be ignored
    send_beat(hdr(7'h60, 32'h1000_0001), 8'hFF, 1'b0, tu(7'h01, 1'b0), 0, 7'h01, 1'b0, 1'b1);
    send_beat(64'h0000_0000_4A00_0000, 8'hFF, 1'b0, tu(7'h7F, 1'b1), 0, 7'h01, 1'b0, 1'b0);
    send_beat(64'hDEAD_BEEF_0123_4567, 8'h0F, 1'b1, tu(7'h7F, 1'b1), 0, 7'h01, 1'b0, 1'b0);
    wait_drain();
    check("mwr_np_ok", rx_np_ok, 1);

    // CplD, 2 beats into a stalled sink: cpl skid fills and rx_tready drops; then toggling ready drains it
    cpl_mode = 3;
    step(2);
    send_beat(hdr(7'h4A, 32'h2000_0002), 8'hFF, 1'b0, tu(7'h00, 1'b0), 1, 7'h00, 1'b0, 1'b1);
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b1, tu(7'h00, 1'b0), 1, 7'h00, 1'b0, 1'b0);
    check("cpl_full_rx_tready", rx_tready, 0);
    check("cpl_full_tvalid", cpl_tvalid, 1);
    cpl_mode = 1;
    wait_drain();
    check("cpl_drained_rx_tready", rx_tready, 1);

    // Drops: Msg (2 beats), MRd with err_fwd, then a CfgRd0
    send_beat(hdr(7'h30, 32'h3000_0003), 8'hFF, 1'b0, tu(7'h02, 1'b0), 2, 7'h00, 1'b0, 1'b1);
    send_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b1, tu(7'h02, 1'b0), 2, 7'h00, 1'b0, 1'b0);
    send_beat(hdr(7'h00, 32'h3000_0004), 8'h0F, 1'b1, tu(7'h02, 1'b1), 2, 7'h00, 1'b0, 1'b1);
    step(3);
    check_stats("drop2");
    check("errfwd_np_ok", rx_np_ok, 1);
    send_beat(hdr(7'h04, 32'h3000_0005), 8'hFF, 1'b1, tu(7'h00, 1'b0), 2, 7'h00, 1'b0, 1'b1);
    wait_drain();
    check_stats("drop3");

    // NP throttle at NP_LIMIT=2; the endpoint holds the third MRd while rx_np_ok is low
    send_beat(hdr(7'h00, 32'h4000_0001), 8'h0F, 1'b1, tu(7'h02, 1'b0), 0, 7'h02, 1'b1, 1'b1);
    send_beat(hdr(7'h00, 32'h4000_0002), 8'h0F, 1'b1, tu(7'h02, 1'b0), 0, 7'h02, 1'b1, 1'b1);
    check("np_ok_lag", rx_np_ok, 1);
    step(1);
    check("np_ok_at_limit", rx_np_ok, 0);
    pulse_np_done();
    check("np_ok_after_done_1", rx_np_ok, 0);
    step(1);
    check("np_ok_after_done_2", rx_np_ok, 1);
    send_beat(hdr(7'h00, 32'h4000_0003), 8'h0F, 1'b1, tu(7'h02, 1'b0), 0, 7'h02, 1'b1, 1'b1);
    step(1);
    check("np_ok_third", rx_np_ok, 0);

    // Coincident MRd + np_done at 1 keeps 1; np_done at 0 saturates
    wait_drain();
    pulse_np_done();
    step(1);
    check("np_one_ok", rx_np_ok, 1);
    np_done = 1'b1;
    send_beat(hdr(7'h00, 32'h5000_0001), 8'h0F, 1'b1, tu(7'h03, 1'b0), 0, 7'h03, 1'b1, 1'b1);
    np_done = 1'b0;
    step(1);
    check("np_coincident_ok", rx_np_ok, 1);
    send_beat(hdr(7'h00, 32'h5000_0002), 8'h0F, 1'b1, tu(7'h03, 1'b0), 0, 7'h03, 1'b1, 1'b1);
    step(1);
    check("np_coincident_then_mrd", rx_np_ok, 0);
    pulse_np_done();
    step(1);
    pulse_np_done();
    step(1);
    pulse_np_done();
    step(2);
    check("np_done_at_zero", rx_np_ok, 1);
    send_beat(hdr(7'h00, 32'h5000_0003), 8'h0F, 1'b1, tu(7'h03, 1'b0), 0, 7'h03, 1'b1, 1'b1);
    step(1);
    check("np_after_zero_mrd", rx_np_ok, 1);
    wait_drain();

    // IOWr (non-posted) and 4-beat MWr under random request backpressure
    req_mode = 2;
    send_beat(hdr(7'h42, 32'h6000_0001), 8'hFF, 1'b0, tu(7'h04, 1'b0), 0, 7'h04, 1'b1, 1'b1);
    send_beat(64'h0000_0000_CAFE_F00D, 8'h0F, 1'b1, tu(7'h00, 1'b0), 0, 7'h04, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_beat((i == 0) ? hdr(7'h60, 32'h6000_0002) : {32'h7000_0000, 32'(i)}, 8'hFF, 1'(i == 3),
                tu((i == 0) ? 7'h10 : 7'h00, 1'b0), 0, 7'h10, 1'b0, 1'(i == 0));
    end
    wait_drain();
    req_mode = 0;
    check_stats("mid");

    // Reset in the middle of a 4-beat MWr held in the req skid
    req_mode = 3;
    step(2);
    send_beat(hdr(7'h60, 32'h8000_0001), 8'hFF, 1'b0, tu(7'h05, 1'b0), 0, 7'h05, 1'b0, 1'b1);
    send_beat(64'h8888_0000_0000_0001, 8'hFF, 1'b0, tu(7'h00, 1'b0), 0, 7'h05, 1'b0, 1'b0);
    check("pre_rst_req_tvalid", req_tvalid, 1);
    user_reset_n = 1'b0;
    #1;
    check("mid_rst_req_tvalid", req_tvalid, 0);
    check("mid_rst_cpl_tvalid", cpl_tvalid, 0);
    check("mid_rst_rx_tready", rx_tready, 0);
    check("mid_rst_state", o_dbg_state, 0);
    exp_req_q.delete();
    exp_req_tlp = 0;
    exp_cpl_tlp = 0;
    exp_drop_tlp = 0;
    check_stats("mid_rst");
    step(2);
    user_reset_n = 1'b1;
    req_mode = 0;
    cpl_mode = 0;
    step(1);
    check("post_rst_rx_tready", rx_tready, 1);
    send_beat(hdr(7'h4A, 32'h9000_0001), 8'hFF, 1'b0, tu(7'h00, 1'b0), 1, 7'h00, 1'b0, 1'b1);
    send_beat(64'h9999_AAAA_BBBB_CCCC, 8'h0F, 1'b1, tu(7'h00, 1'b0), 1, 7'h00, 1'b0, 1'b0);
    wait_drain();
    check_stats("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
